// File: rtl/id_exe_pipe_reg_if.sv
// rtl/id_exe_pipe_reg_if.sv - ID-side fields into the ID/EXE register and registered copies out
interface id_exe_pipe_reg_if #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
);
  logic            ID_valid;
  logic [RA_W-1:0] ID_read_reg1;
  logic [RA_W-1:0] ID_read_reg2;
  logic            ID_use_rs1;
  logic            ID_use_rs2;
  logic [XLEN-1:0] ID_ALU_A;
  logic [XLEN-1:0] ID_ALU_B;
  logic [XLEN-1:0] ID_data_out;
  logic            ID_mem_w;
  logic            ID_mem_r;
  logic            ID_reg_write;
  logic [RA_W-1:0] ID_written_reg;
  logic [XLEN-1:0] ID_pc;

  logic            ID_EXE_valid;
  logic [RA_W-1:0] ID_EXE_read_reg1;
  logic [RA_W-1:0] ID_EXE_read_reg2;
  logic            ID_EXE_use_rs1;
  logic            ID_EXE_use_rs2;
  logic [XLEN-1:0] ID_EXE_ALU_A;
  logic [XLEN-1:0] ID_EXE_ALU_B;
  logic [XLEN-1:0] ID_EXE_data_out;
  logic            ID_EXE_mem_w;
  logic            ID_EXE_mem_r;
  logic            ID_EXE_reg_write;
  logic [RA_W-1:0] ID_EXE_written_reg;
  logic [XLEN-1:0] ID_EXE_pc;

  modport master (
    output ID_valid, ID_read_reg1, ID_read_reg2, ID_use_rs1, ID_use_rs2,
           ID_ALU_A, ID_ALU_B, ID_data_out, ID_mem_w, ID_mem_r,
           ID_reg_write, ID_written_reg, ID_pc,
    input  ID_EXE_valid, ID_EXE_read_reg1, ID_EXE_read_reg2, ID_EXE_use_rs1,
           ID_EXE_use_rs2, ID_EXE_ALU_A, ID_EXE_ALU_B, ID_EXE_data_out,
           ID_EXE_mem_w, ID_EXE_mem_r, ID_EXE_reg_write, ID_EXE_written_reg,
           ID_EXE_pc
  );

  modport slave (
    input  ID_valid, ID_read_reg1, ID_read_reg2, ID_use_rs1, ID_use_rs2,
           ID_ALU_A, ID_ALU_B, ID_data_out, ID_mem_w, ID_mem_r,
           ID_reg_write, ID_written_reg, ID_pc,
    output ID_EXE_valid, ID_EXE_read_reg1, ID_EXE_read_reg2, ID_EXE_use_rs1,
           ID_EXE_use_rs2, ID_EXE_ALU_A, ID_EXE_ALU_B, ID_EXE_data_out,
           ID_EXE_mem_w, ID_EXE_mem_r, ID_EXE_reg_write, ID_EXE_written_reg,
           ID_EXE_pc
  );
endinterface

// File: rtl/id_exe_pipe_reg.sv
// rtl/id_exe_pipe_reg.sv - ID/EXE pipeline register with load-use bubble insertion
// Flush and load-use load an all-zero bubble; mem_stall freezes the stage.
module id_exe_pipe_reg #(
  parameter int XLEN  = 32,
  parameter int RA_W  = 5,
  parameter int CNT_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  id_exe_pipe_reg_if.slave   bus,
  input  logic               flush,
  input  logic               mem_stall,
  output logic               stall_ID,
  output logic [CNT_W-1:0]   bubble_cnt
);

  typedef struct packed {
    logic            valid;
    logic [RA_W-1:0] read_reg1;
    logic [RA_W-1:0] read_reg2;
    logic            use_rs1;
    logic            use_rs2;
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [XLEN-1:0] data_out;
    logic            mem_w;
    logic            mem_r;
    logic            reg_write;
    logic [RA_W-1:0] written_reg;
    logic [XLEN-1:0] pc;
  } stage_t;

  stage_t            id_fields;
  stage_t            stage_d;
  stage_t            stage_q;
  logic [CNT_W-1:0]  bubble_cnt_d;
  logic [CNT_W-1:0]  bubble_cnt_q;
  logic              lu;
  logic              rs1_hit;
  logic              rs2_hit;

  always_comb begin
    id_fields.valid       = bus.ID_valid;
    id_fields.read_reg1   = bus.ID_read_reg1;
    id_fields.read_reg2   = bus.ID_read_reg2;
    id_fields.use_rs1     = bus.ID_use_rs1;
    id_fields.use_rs2     = bus.ID_use_rs2;
    id_fields.alu_a       = bus.ID_ALU_A;
    id_fields.alu_b       = bus.ID_ALU_B;
    id_fields.data_out    = bus.ID_data_out;
    id_fields.mem_w       = bus.ID_mem_w;
    id_fields.mem_r       = bus.ID_mem_r;
    id_fields.reg_write   = bus.ID_reg_write;
    id_fields.written_reg = bus.ID_written_reg;
    id_fields.pc          = bus.ID_pc;
  end

  // x0 is never a real destination, so a load to it cannot create a hazard.
  assign rs1_hit = bus.ID_use_rs1 && (stage_q.written_reg == bus.ID_read_reg1);
  assign rs2_hit = bus.ID_use_rs2 && (stage_q.written_reg == bus.ID_read_reg2);
  assign lu      = stage_q.mem_r && bus.ID_valid &&
                   (stage_q.written_reg != '0) && (rs1_hit || rs2_hit);

  always_comb begin
    stage_d      = stage_q;
    bubble_cnt_d = bubble_cnt_q;
    if (!mem_stall) begin
      if (flush || lu) begin
        stage_d      = '0;
        bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
      end else begin
        stage_d      = id_fields;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q      <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stage_q      <= stage_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  // A flushed ID instruction is being squashed anyway, so it is not held.
  assign stall_ID   = !rst && (mem_stall || (lu && !flush));
  assign bubble_cnt = bubble_cnt_q;

  assign bus.ID_EXE_valid       = stage_q.valid;
  assign bus.ID_EXE_read_reg1   = stage_q.read_reg1;
  assign bus.ID_EXE_read_reg2   = stage_q.read_reg2;
  assign bus.ID_EXE_use_rs1     = stage_q.use_rs1;
  assign bus.ID_EXE_use_rs2     = stage_q.use_rs2;
  assign bus.ID_EXE_ALU_A       = stage_q.alu_a;
  assign bus.ID_EXE_ALU_B       = stage_q.alu_b;
  assign bus.ID_EXE_data_out    = stage_q.data_out;
  assign bus.ID_EXE_mem_w       = stage_q.mem_w;
  assign bus.ID_EXE_mem_r       = stage_q.mem_r;
  assign bus.ID_EXE_reg_write   = stage_q.reg_write;
  assign bus.ID_EXE_written_reg = stage_q.written_reg;
  assign bus.ID_EXE_pc          = stage_q.pc;

endmodule

// File: tb/tb_id_exe_pipe_reg.sv
// tb/tb_id_exe_pipe_reg.sv - scoreboard bench for the ID/EXE pipeline register
module tb_id_exe_pipe_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        mem_stall;
  logic        stall_ID;
  logic [31:0] bubble_cnt;

  always #5 clk = ~clk;

  id_exe_pipe_reg_if #(.XLEN(32), .RA_W(5)) bus ();

  id_exe_pipe_reg #(.XLEN(32), .RA_W(5), .CNT_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .flush      (flush),
    .mem_stall  (mem_stall),
    .stall_ID   (stall_ID),
    .bubble_cnt (bubble_cnt)
  );

  typedef struct packed {
    logic        valid;
    logic [4:0]  rr1;
    logic [4:0]  rr2;
    logic        u1;
    logic        u2;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] d;
    logic        mw;
    logic        mr;
    logic        rw;
    logic [4:0]  wr;
    logic [31:0] pc;
  } st_t;

  typedef struct packed {
    st_t         s;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb[$];
  st_t         m_s;
  logic [31:0] m_cnt;
  logic [31:0] pc_ctr;
  string       tag;
  int          vectors = 0;
  int          miscompares = 0;

  function automatic st_t mk(input logic mr, input logic rw, input logic u1, input logic u2,
                             input logic [4:0] rr1, input logic [4:0] rr2, input logic [4:0] wr,
                             input logic [31:0] a, input logic [31:0] b);
    st_t s;
    s.valid = 1'b1;
    s.rr1 = rr1;
    s.rr2 = rr2;
    s.u1 = u1;
    s.u2 = u2;
    s.a = a;
    s.b = b;
    s.d = a ^ b;
    s.mw = 1'b0;
    s.mr = mr;
    s.rw = rw;
    s.wr = wr;
    s.pc = pc_ctr;
    return s;
  endfunction

  task automatic set_id(input st_t s);
    bus.ID_valid       = s.valid;
    bus.ID_read_reg1   = s.rr1;
    bus.ID_read_reg2   = s.rr2;
    bus.ID_use_rs1     = s.u1;
    bus.ID_use_rs2     = s.u2;
    bus.ID_ALU_A       = s.a;
    bus.ID_ALU_B       = s.b;
    bus.ID_data_out    = s.d;
    bus.ID_mem_w       = s.mw;
    bus.ID_mem_r       = s.mr;
    bus.ID_reg_write   = s.rw;
    bus.ID_written_reg = s.wr;
    bus.ID_pc          = s.pc;
    pc_ctr             = pc_ctr + 32'd4;
  endtask

  function automatic st_t id_view();
    return {bus.ID_valid, bus.ID_read_reg1, bus.ID_read_reg2, bus.ID_use_rs1, bus.ID_use_rs2,
            bus.ID_ALU_A, bus.ID_ALU_B, bus.ID_data_out, bus.ID_mem_w, bus.ID_mem_r,
            bus.ID_reg_write, bus.ID_written_reg, bus.ID_pc};
  endfunction

  function automatic st_t exe_view();
    return {bus.ID_EXE_valid, bus.ID_EXE_read_reg1, bus.ID_EXE_read_reg2, bus.ID_EXE_use_rs1,
            bus.ID_EXE_use_rs2, bus.ID_EXE_ALU_A, bus.ID_EXE_ALU_B, bus.ID_EXE_data_out,
            bus.ID_EXE_mem_w, bus.ID_EXE_mem_r, bus.ID_EXE_reg_write, bus.ID_EXE_written_reg,
            bus.ID_EXE_pc};
  endfunction

  // Called just after a falling edge with inputs settled; scores one rising edge.
  task automatic clock_and_score();
    st_t  id;
    st_t  got;
    exp_t e;
    logic lu;
    logic exp_stall;
    id = id_view();
    #1;
    lu = m_s.mr && id.valid && (m_s.wr != 5'd0) &&
         ((id.u1 && (m_s.wr == id.rr1)) || (id.u2 && (m_s.wr == id.rr2)));
    exp_stall = rst ? 1'b0 : (mem_stall || (lu && !flush));
    vectors++;
    if (stall_ID !== exp_stall) begin
      miscompares++;
      $display("FAIL %s stall_ID got=%b exp=%b", tag, stall_ID, exp_stall);
    end
    if (rst) begin
      m_s = '0;
      m_cnt = 32'd0;
    end else if (mem_stall) begin
      m_cnt = m_cnt;
    end else if (flush || lu) begin
      m_s = '0;
      m_cnt = m_cnt + 32'd1;
    end else begin
      m_s = id;
    end
    sb.push_back({m_s, m_cnt});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    got = exe_view();
    vectors++;
    if (got !== e.s) begin
      miscompares++;
      $display("FAIL %s id_exe got=%h exp=%h", tag, got, e.s);
    end
    vectors++;
    if (bubble_cnt !== e.cnt) begin
      miscompares++;
      $display("FAIL %s bubble_cnt got=%0d exp=%0d", tag, bubble_cnt, e.cnt);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    tag = "reset";
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      set_id(mk(1'($urandom), 1'b1, 1'b1, 1'b1, 5'($urandom), 5'($urandom), 5'($urandom),
                $urandom, $urandom));
      flush = 1'($urandom);
      mem_stall = 1'($urandom);
      clock_and_score();
    end
    vectors++;
    if (exe_view() !== '0 || stall_ID !== 1'b0 || bubble_cnt !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_state got=%h/%b/%0d exp=0/0/0", exe_view(), stall_ID, bubble_cnt);
    end
    rst = 1'b0;
    flush = 1'b0;
    mem_stall = 1'b0;
  endtask

  task automatic test_pass_through();
    tag = "pass_through";
    set_id(mk(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd5, 32'h11, 32'h22));
    clock_and_score();
    vectors++;
    if (bus.ID_EXE_ALU_A !== 32'h11 || bus.ID_EXE_ALU_B !== 32'h22 ||
        bus.ID_EXE_written_reg !== 5'd5 || bus.ID_EXE_reg_write !== 1'b1) begin
      miscompares++;
      $display("FAIL pass_through got=%h/%h/%0d/%b exp=11/22/5/1", bus.ID_EXE_ALU_A,
               bus.ID_EXE_ALU_B, bus.ID_EXE_written_reg, bus.ID_EXE_reg_write);
    end
  endtask

  task automatic test_load_use();
    tag = "load_use";
    set_id(mk(1'b1, 1'b1, 1'b1, 1'b0, 5'd2, 5'd0, 5'd5, 32'h100, 32'h4));
    clock_and_score();
    set_id(mk(1'b0, 1'b1, 1'b1, 1'b1, 5'd5, 5'd1, 5'd6, 32'hAAA, 32'hBBB));
    #1;
    vectors++;
    if (stall_ID !== 1'b1) begin
      miscompares++;
      $display("FAIL load_use_stall got=%b exp=1", stall_ID);
    end
    clock_and_score();
    vectors++;
    if (bus.ID_EXE_valid !== 1'b0 || bus.ID_EXE_mem_r !== 1'b0 || bubble_cnt !== 32'd1) begin
      miscompares++;
      $display("FAIL load_use_bubble got=%b/%b/%0d exp=0/0/1", bus.ID_EXE_valid,
               bus.ID_EXE_mem_r, bubble_cnt);
    end
    #1;
    vectors++;
    if (stall_ID !== 1'b0) begin
      miscompares++;
      $display("FAIL load_use_release got=%b exp=0", stall_ID);
    end
    clock_and_score();
    vectors++;
    if (bus.ID_EXE_valid !== 1'b1 || bus.ID_EXE_written_reg !== 5'd6 ||
        bus.ID_EXE_ALU_A !== 32'hAAA) begin
      miscompares++;
      $display("FAIL load_use_add got=%b/%0d/%h exp=1/6/aaa", bus.ID_EXE_valid,
               bus.ID_EXE_written_reg, bus.ID_EXE_ALU_A);
    end
  endtask

  task automatic test_no_false_hazard();
    tag = "no_false_hazard";
    set_id(mk(1'b1, 1'b1, 1'b1, 1'b0, 5'd3, 5'd0, 5'd0, 32'h1, 32'h2));
    clock_and_score();
    set_id(mk(1'b0, 1'b1, 1'b1, 1'b1, 5'd0, 5'd0, 5'd7, 32'h3, 32'h4));
    #1;
    vectors++;
    if (stall_ID !== 1'b0) begin
      miscompares++;
      $display("FAIL lw_x0_stall got=%b exp=0", stall_ID);
    end
    clock_and_score();
    set_id(mk(1'b1, 1'b1, 1'b1, 1'b0, 5'd3, 5'd0, 5'd5, 32'h5, 32'h6));
    clock_and_score();
    set_id(mk(1'b0, 1'b1, 1'b1, 1'b0, 5'd3, 5'd5, 5'd8, 32'h7, 32'h8));
    #1;
    vectors++;
    if (stall_ID !== 1'b0) begin
      miscompares++;
      $display("FAIL unused_rs2_stall got=%b exp=0", stall_ID);
    end
    clock_and_score();
    vectors++;
    if (bus.ID_EXE_written_reg !== 5'd8 || bus.ID_EXE_valid !== 1'b1 || bubble_cnt !== 32'd1) begin
      miscompares++;
      $display("FAIL unused_rs2_load got=%0d/%b/%0d exp=8/1/1", bus.ID_EXE_written_reg,
               bus.ID_EXE_valid, bubble_cnt);
    end
  endtask

  task automatic test_flush_lu();
    tag = "flush_lu";
    set_id(mk(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd5, 32'h9, 32'hA));
    clock_and_score();
    set_id(mk(1'b0, 1'b1, 1'b1, 1'b1, 5'd5, 5'd5, 5'd6, 32'hB, 32'hC));
    flush = 1'b1;
    #1;
    vectors++;
    if (stall_ID !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_lu_stall got=%b exp=0", stall_ID);
    end
    clock_and_score();
    flush = 1'b0;
    vectors++;
    if (bus.ID_EXE_valid !== 1'b0 || bubble_cnt !== 32'd2) begin
      miscompares++;
      $display("FAIL flush_lu_bubble got=%b/%0d exp=0/2", bus.ID_EXE_valid, bubble_cnt);
    end
  endtask

  task automatic test_mem_stall();
    tag = "mem_stall";
    set_id(mk(1'b0, 1'b1, 1'b1, 1'b1, 5'd1, 5'd2, 5'd9, 32'h1234, 32'h5678));
    clock_and_score();
    set_id(mk(1'b0, 1'b1, 1'b1, 1'b1, 5'd3, 5'd4, 5'd10, 32'h9999, 32'h7777));
    mem_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++;
      if (stall_ID !== 1'b1) begin
        miscompares++;
        $display("FAIL mem_stall_stall got=%b exp=1", stall_ID);
      end
      clock_and_score();
      vectors++;
      if (bus.ID_EXE_ALU_A !== 32'h1234 || bus.ID_EXE_written_reg !== 5'd9 ||
          bubble_cnt !== 32'd2) begin
        miscompares++;
        $display("FAIL mem_stall_hold got=%h/%0d/%0d exp=1234/9/2", bus.ID_EXE_ALU_A,
                 bus.ID_EXE_written_reg, bubble_cnt);
      end
    end
    mem_stall = 1'b0;
    clock_and_score();
    vectors++;
    if (bus.ID_EXE_ALU_A !== 32'h9999 || bus.ID_EXE_written_reg !== 5'd10) begin
      miscompares++;
      $display("FAIL mem_stall_resume got=%h/%0d exp=9999/10", bus.ID_EXE_ALU_A,
               bus.ID_EXE_written_reg);
    end
  endtask

  task automatic test_reset_mid_stall();
    tag = "reset_mid_stall";
    set_id(mk(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd5, 32'h55, 32'h66));
    clock_and_score();
    set_id(mk(1'b0, 1'b1, 1'b1, 1'b0, 5'd5, 5'd0, 5'd6, 32'h77, 32'h88));
    mem_stall = 1'b1;
    clock_and_score();
    rst = 1'b1;
    #1;
    vectors++;
    if (stall_ID !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_forces_stall got=%b exp=0", stall_ID);
    end
    clock_and_score();
    vectors++;
    if (bus.ID_EXE_valid !== 1'b0 || bus.ID_EXE_mem_r !== 1'b0 || bubble_cnt !== 32'd0) begin
      miscompares++;
      $display("FAIL rst_drop got=%b/%b/%0d exp=0/0/0", bus.ID_EXE_valid, bus.ID_EXE_mem_r,
               bubble_cnt);
    end
    rst = 1'b0;
    mem_stall = 1'b0;
    set_id(mk(1'b0, 1'b1, 1'b1, 1'b0, 5'd5, 5'd0, 5'd12, 32'hC0DE, 32'h1));
    clock_and_score();
    vectors++;
    if (bus.ID_EXE_written_reg !== 5'd12 || bus.ID_EXE_ALU_A !== 32'hC0DE) begin
      miscompares++;
      $display("FAIL rst_resume got=%0d/%h exp=12/c0de", bus.ID_EXE_written_reg,
               bus.ID_EXE_ALU_A);
    end
  endtask

  task automatic test_back_to_back();
    st_t s;
    tag = "back_to_back";
    for (int i = 0; i < 300; i++) begin
      s = mk(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), $urandom, $urandom);
      s.valid = ($urandom_range(0, 7) != 0);
      s.mw = 1'($urandom);
      set_id(s);
      rst = ($urandom_range(0, 49) == 0);
      mem_stall = ($urandom_range(0, 5) == 0);
      flush = ($urandom_range(0, 7) == 0);
      clock_and_score();
    end
    rst = 1'b0;
    mem_stall = 1'b0;
    flush = 1'b0;
  endtask

  initial begin
    pc_ctr = 32'h1000;
    m_s = '0;
    m_cnt = 32'd0;
    rst = 1'b1;
    flush = 1'b0;
    mem_stall = 1'b0;
    set_id('0);
    @(negedge clk);
    test_reset();
    test_pass_through();
    test_load_use();
    test_no_false_hazard();
    test_flush_lu();
    test_mem_stall();
    test_reset_mid_stall();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
